// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_encoder_pkg : shared types and opcode constants for the RV32I   |
// | instruction encoder.                            Revision: 1.0         |
// +----------------------------------------------------------------------+
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    INS_R       = 3'd0,
    INS_I       = 3'd1,
    INS_S       = 3'd2,
    INS_B       = 3'd3,
    INS_U       = 3'd4,
    INS_J       = 3'd5,
    INS_INVALID = 3'd6
  } instype_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_OPCODE = 2'd1,
    ERR_RANGE  = 2'd2,
    ERR_ALIGN  = 2'd3
  } enc_err_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic instype_t op_to_type(input logic [6:0] op);
    instype_t t;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: t = INS_I;
      OP_REG:                   t = INS_R;
      OP_STORE:                 t = INS_S;
      OP_BRANCH:                t = INS_B;
      OP_LUI, OP_AUIPC:         t = INS_U;
      OP_JAL:                   t = INS_J;
      default:                  t = INS_INVALID;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_pack : combinational RV32I field packer with immediate checks.  |
// |                                                 Revision: 1.0         |
// +----------------------------------------------------------------------+
module instr_pack
  import instr_encoder_pkg::*;
(
  input  instype_t    ins_type,
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [9:0]  func,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output enc_err_t    err
);

  logic signed [31:0] simm;
  logic [6:0]         funct7;
  logic [2:0]         funct3;
  logic               fits_12;
  logic               fits_b;
  logic               fits_j;

  assign simm    = $signed(imm);
  assign funct7  = func[9:3];
  assign funct3  = func[2:0];
  assign fits_12 = (simm >= -32'sd2048)    && (simm <= 32'sd2047);
  assign fits_b  = (simm >= -32'sd4096)    && (simm <= 32'sd4094);
  assign fits_j  = (simm >= -32'sd1048576) && (simm <= 32'sd1048574);

  always_comb begin
    word = 32'd0;
    err  = ERR_NONE;
    case (ins_type)
      INS_R: begin
        word = {funct7, rs2, rs1, funct3, rd, op};
      end
      INS_I: begin
        word = {imm[11:0], rs1, funct3, rd, op};
        if (!fits_12) err = ERR_RANGE;
      end
      INS_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        if (!fits_12) err = ERR_RANGE;
      end
      INS_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        if (!fits_b)     err = ERR_RANGE;
        else if (imm[0]) err = ERR_ALIGN;
      end
      INS_U: begin
        word = {imm[31:12], rd, op};
        if (imm[11:0] != 12'd0) err = ERR_ALIGN;
      end
      INS_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        if (!fits_j)     err = ERR_RANGE;
        else if (imm[0]) err = ERR_ALIGN;
      end
      default: begin
        err = ERR_OPCODE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_encoder : streaming RV32I encoder with 2-entry output FIFO and  |
// | word-address tagging.                           Revision: 1.0         |
// +----------------------------------------------------------------------+
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [9:0]        in_func,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              addr_clr,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  instype_t    ins_type;
  logic [31:0] pack_word;
  enc_err_t    pack_err;

  assign ins_type = op_to_type(in_op);

  instr_pack u_pack (
    .ins_type (ins_type),
    .op       (in_op),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .func     (in_func),
    .imm      (in_imm),
    .word     (pack_word),
    .err      (pack_err)
  );

  // Slot 0 is always the FIFO head; pops shift slot 1 down.
  logic [1:0][31:0]       instr_q, instr_d;
  logic [1:0][ADDR_W-1:0] tag_q, tag_d;
  logic [1:0]             count_q, count_d;
  logic                   in_ready_q, in_ready_d;
  logic [ADDR_W-1:0]      addr_cnt_q, addr_cnt_d;
  logic                   err_valid_q, err_valid_d;
  enc_err_t               err_code_q, err_code_d;

  logic                   accept;
  logic                   push;
  logic                   pop;
  logic [ADDR_W-1:0]      cur_addr;

  always_comb begin
    accept   = in_valid & in_ready_q;
    push     = accept & (pack_err == ERR_NONE);
    pop      = (count_q != 2'd0) & out_ready;
    cur_addr = addr_clr ? BASE_ADDR : addr_cnt_q;

    instr_d = instr_q;
    tag_d   = tag_q;
    if (pop) begin
      instr_d[0] = instr_q[1];
      tag_d[0]   = tag_q[1];
    end
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        instr_d[0] = pack_word;
        tag_d[0]   = cur_addr;
      end else begin
        instr_d[1] = pack_word;
        tag_d[1]   = cur_addr;
      end
    end

    count_d    = count_q + 2'(push) - 2'(pop);
    in_ready_d = (count_d < 2'd2);

    addr_cnt_d = addr_cnt_q;
    if (push)          addr_cnt_d = cur_addr + ADDR_W'(1);
    else if (addr_clr) addr_cnt_d = BASE_ADDR;

    err_valid_d = accept & (pack_err != ERR_NONE);
    err_code_d  = err_valid_d ? pack_err : err_code_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q     <= '0;
      tag_q       <= {2{BASE_ADDR}};
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      addr_cnt_q  <= BASE_ADDR;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      instr_q     <= instr_d;
      tag_q       <= tag_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      addr_cnt_q  <= addr_cnt_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = instr_q[0];
  assign out_addr  = tag_q[0];
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_encoder : scoreboard bench for instr_encoder (ADDR_W = 2).   |
// |                                                 Revision: 1.0         |
// +----------------------------------------------------------------------+
module tb_instr_encoder;

  localparam int         ADDR_W = 2;
  localparam logic [1:0] BASE   = 2'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [9:0]  in_func = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [1:0]  out_addr;
  logic        addr_clr = 1'b0;
  logic        err_valid;
  logic [1:0]  err_code;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_func   (in_func),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .addr_clr  (addr_clr),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   checks = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  int   m_count = 0;
  bit   exp_push = 1'b0;
  bit   exp_rej = 1'b0;
  bit   rej_pending = 1'b0;
  int   last_code = 0;
  int   addr_m = 0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the RV32I field layout with shifts and masks.
  function automatic void model(input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [9:0] func, input logic [31:0] imm,
                                output logic [31:0] w, output int code);
    int          v  = $signed(imm);
    int unsigned u  = imm;
    int unsigned f3 = func & 10'h7;
    int unsigned f7 = func >> 3;
    int unsigned rr = (32'(rs1) << 15) | (f3 << 12);
    w    = 32'd0;
    code = 0;
    case (op)
      7'h13, 7'h03, 7'h67: begin
        if (v < -2048 || v > 2047) code = 2;
        w = ((u & 32'hFFF) << 20) | rr | (32'(rd) << 7) | 32'(op);
      end
      7'h33: w = (f7 << 25) | (32'(rs2) << 20) | rr | (32'(rd) << 7) | 32'(op);
      7'h23: begin
        if (v < -2048 || v > 2047) code = 2;
        w = (((u >> 5) & 127) << 25) | (32'(rs2) << 20) | rr | ((u & 31) << 7) | 32'(op);
      end
      7'h63: begin
        if (v < -4096 || v > 4094) code = 2;
        else if ((u & 1) != 0)     code = 3;
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (32'(rs2) << 20) | rr
          | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'(op);
      end
      7'h37, 7'h17: begin
        if ((u & 32'hFFF) != 0) code = 3;
        w = (u & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      end
      7'h6F: begin
        if (v < -1048576 || v > 1048574) code = 2;
        else if ((u & 1) != 0)           code = 3;
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
          | (((u >> 12) & 255) << 12) | (32'(rd) << 7) | 32'(op);
      end
      default: code = 1;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = (($urandom % 4) != 0);
    endcase
  end

  // Starts and ends at one time unit after a rising edge.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [9:0] func, input logic [31:0] imm,
                      input bit clr = 1'b0, input bit has_exp = 1'b0,
                      input logic [31:0] exp_w = 32'd0, input int exp_code = 0);
    logic [31:0] w;
    int          code;
    int          n;
    int          cur;
    in_valid = 1'b1;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_func = func; in_imm = imm;
    addr_clr = clr;
    #2;
    n = 0;
    while (!in_ready && n < 200) begin
      if (clr) addr_m = BASE;
      @(posedge clk); #3;
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: actual in_ready 0 required 1 at %0t", $time);
    end else begin
      model(op, rd, rs1, rs2, func, imm, w, code);
      if (has_exp) begin
        w    = exp_w;
        code = exp_code;
      end
      cur = clr ? int'(BASE) : addr_m;
      if (code == 0) begin
        exp_q.push_back('{instr: w, addr: 2'(cur)});
        addr_m   = (cur + 1) % 4;
        exp_push = 1'b1;
      end else begin
        err_q.push_back(code);
        if (clr) addr_m = BASE;
        exp_rej = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    addr_clr = 1'b0;
    exp_push = 1'b0;
    exp_rej  = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("out_valid", out_valid, m_count != 0);
      chk("in_ready", in_ready, m_count < 2);
      chk("err_valid", err_valid, rej_pending);
      if (err_valid && err_q.size() != 0) last_code = err_q.pop_front();
      chk("err_code", err_code, last_code);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_with_empty_scoreboard", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_addr", out_addr, e.addr);
        end
      end
      m_count     = m_count + int'(exp_push) - int'((m_count != 0) && out_ready);
      rej_pending = exp_rej;
    end
  end

  initial begin
    logic [6:0]  op;
    logic [31:0] imm;
    logic [6:0]  ops[9] = '{7'h13, 7'h03, 7'h67, 7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", out_addr, BASE);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    mon_en   = 1'b1;
    rdy_mode = 1;

    send(7'h13, 5'd1, 5'd0, 5'd0, 10'd0, 32'd5, 1'b0, 1'b1, 32'h00500093, 0);
    send(7'h33, 5'd3, 5'd1, 5'd2, 10'd0, 32'd0, 1'b1, 1'b1, 32'h002081B3, 0);
    send(7'h23, 5'd0, 5'd1, 5'd2, 10'd2, 32'd8, 1'b0, 1'b1, 32'h0020A423, 0);
    send(7'h63, 5'd0, 5'd0, 5'd0, 10'd0, -32'sd4, 1'b0, 1'b1, 32'hFE000EE3, 0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 10'd0, 32'h12345000, 1'b0, 1'b1, 32'h123452B7, 0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 10'd0, 32'd2048, 1'b0, 1'b1, 32'd0, 2);
    send(7'h63, 5'd0, 5'd0, 5'd0, 10'd0, 32'd3, 1'b0, 1'b1, 32'd0, 3);
    send(7'h7F, 5'd0, 5'd0, 5'd0, 10'd0, 32'd0, 1'b0, 1'b1, 32'd0, 1);
    send(7'h13, 5'd2, 5'd3, 5'd0, 10'd0, 32'd2047);
    send(7'h13, 5'd2, 5'd3, 5'd0, 10'd0, -32'sd2048);
    send(7'h13, 5'd2, 5'd3, 5'd0, 10'd0, -32'sd2049, 1'b0, 1'b1, 32'd0, 2);
    send(7'h63, 5'd0, 5'd4, 5'd5, 10'd1, 32'd4094);
    send(7'h63, 5'd0, 5'd4, 5'd5, 10'd1, 32'd4095, 1'b0, 1'b1, 32'd0, 2);
    send(7'h63, 5'd0, 5'd4, 5'd5, 10'd1, -32'sd4096);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 10'd0, 32'd1048574);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 10'd0, 32'd1048576, 1'b0, 1'b1, 32'd0, 2);
    send(7'h17, 5'd7, 5'd0, 5'd0, 10'd0, 32'h00001004, 1'b0, 1'b1, 32'd0, 3);
    idle(3);

    rdy_mode = 0;
    fork
      begin
        send(7'h13, 5'd1, 5'd0, 5'd0, 10'd0, 32'd1, 1'b1);
        send(7'h13, 5'd2, 5'd0, 5'd0, 10'd0, 32'd2);
        send(7'h13, 5'd3, 5'd0, 5'd0, 10'd0, 32'd3);
      end
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 1;
      end
    join
    idle(4);

    for (int i = 0; i < 5; i++)
      send(7'h13, 5'(i), 5'd0, 5'd0, 10'd0, 32'(i + 10), i == 0);
    send(7'h13, 5'd9, 5'd0, 5'd0, 10'd0, 32'd9, 1'b1);
    idle(3);

    rdy_mode = 0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 10'd0, 32'd1);
    send(7'h13, 5'd2, 5'd0, 5'd0, 10'd0, 32'd2);
    #3;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_addr", out_addr, BASE);
    exp_q.delete();
    err_q.delete();
    m_count = 0; addr_m = BASE; rej_pending = 1'b0; last_code = 0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    mon_en   = 1'b1;
    rdy_mode = 2;

    for (int i = 0; i < 300; i++) begin
      op = ((($urandom % 10)) == 0) ? 7'($urandom) : ops[$urandom % 9];
      case ($urandom % 4)
        0:       imm = $urandom;
        1:       imm = 32'(int'($urandom_range(0, 8192)) - 4096);
        2:       imm = 32'(int'($urandom_range(0, 2200000)) - 1100000);
        default: imm = ($urandom & 32'hFFFFF000) | ((($urandom % 2) == 0) ? 32'd0 : 32'($urandom % 16));
      endcase
      send(op, 5'($urandom), 5'($urandom), 5'($urandom), 10'($urandom), imm,
           ($urandom % 10) == 0);
      if (($urandom % 8) == 0) idle(1);
    end

    rdy_mode = 1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    idle(2);
    chk("drain_words_left", exp_q.size(), 0);
    chk("drain_errs_left", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder; the inverse of the instruction decoder.
- Accepts decoded fields (opcode, registers, func, full-width immediate) over a valid/ready handshake and range-checks the immediate.
- Packs the fields into a 32-bit instruction word and emits it, tagged with a word address, through a 2-entry output FIFO.
- Used by the program loader and by the test infrastructure to build instruction memory images.

Parameters:
- ADDR_W, 10, width of the word-address counter attached to each output word.
- BASE_ADDR, 0, value the address counter takes on reset and on addr_clr.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_op  in  7  opcode (instr[6:0] value).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_func  in  10  {funct7, funct3}; funct3 = in_func[2:0].
- in_imm  in  32  signed byte-offset or value immediate.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_instr  out  32  encoded word at the FIFO head.
- out_addr  out  ADDR_W  word address of the head.
- addr_clr  in  1  synchronous restart of the address counter.
- err_valid  out  1  one-cycle pulse: a request was rejected.
- err_code  out  2  1 = invalid opcode, 2 = immediate out of range, 3 = misaligned immediate; holds its last value.

Behaviour:
- Reset values: out_valid=0, in_ready=1, err_valid=0, err_code=0, address counter=BASE_ADDR, FIFO empty, out_instr=0, out_addr=BASE_ADDR.
- Reset asserted mid-operation discards all FIFO contents immediately.
- Instruction type from in_op:
  - 0010011, 0000011, 1100111 -> I
  - 0110011 -> R
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - anything else -> invalid
- Encoding is standard RV32I:
  - R uses funct7 and funct3.
  - I uses imm[11:0] and funct3.
  - S splits imm[11:5] / imm[4:0].
  - B places imm[12|10:5|4:1|11].
  - U places imm[31:12].
  - J places imm[20|10:1|11|19:12].
  - Fields not used by a type are ignored.
- Immediate checks, in priority order: opcode invalid -> code 1; range -> code 2; alignment -> code 3.
  - I, S: imm must lie in -2048..2047.
  - B: imm must lie in -4096..4094 and imm[0]=0.
  - J: imm must lie in -1048576..1048574 and imm[0]=0.
  - U: imm[11:0] must be 0, otherwise code 3.
  - R: imm is ignored.
- Handshake:
  - A request is accepted on a rising edge with in_valid & in_ready.
  - in_ready = (FIFO count < 2), registered; there is no combinational path from out_ready.
  - The head pops on out_valid & out_ready.
- Latency: a valid request accepted at edge N is visible on out_* after edge N when the FIFO was empty or popped at N.
- Push and pop in the same cycle with count 1 leaves count at 1 and preserves order.
- Rejected request:
  - It is consumed: no FIFO push, no address increment.
  - err_valid=1 for exactly the cycle after acceptance; err_code is updated.
- Address counter:
  - Each pushed word is tagged with the current address, then the counter increments.
  - Wraps from 2^ADDR_W-1 to 0.
  - addr_clr forces the current address to BASE_ADDR for a push in the same cycle; the counter becomes BASE_ADDR+1 if a push occurs, else BASE_ADDR.
  - addr_clr does not affect words already in the FIFO.

Decomposition:
- Shared defs package: instype_t (already holds INS_R/I/S/B/U/J/INVALID), new opcode constants (OP_IMM, OP_REG, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), and an enc_err_t enum for err_code.
- One sub-module: instr_pack, purely combinational.
  - Inputs: type plus fields.
  - Outputs: 32-bit word and error code.
- The top level holds the handshake, FIFO and address counter.

Test Plan:
- ADDI x1,x0,5 (op 0010011, rd 1, func 0, imm 5) -> out_instr 0x00500093, out_addr 0, latency 1.
- ADD x3,x1,x2 then SW x2,8(x1) (func 010) -> 0x002081B3 at addr 0, then 0x0020A423 at addr 1.
- BEQ x0,x0,-4 -> 0xFE000EE3; LUI x5, imm 0x12345000 -> 0x123452B7.
- Error cases (no push, address unchanged):
  - ADDI with imm 2048 -> err_valid pulse, err_code 2.
  - BEQ with imm 3 -> code 3.
  - op 0x7F -> code 1.
- Backpressure: out_ready=0, present 3 valid requests -> in_ready low after 2 accepts; release out_ready -> words drain in order, third accepted, addresses 0,1,2.
- Wrap and reset:
  - ADDR_W=2, push 5 words -> addresses 0,1,2,3,0.
  - addr_clr with a push -> that word tagged BASE_ADDR.
  - rst with 2 words queued -> out_valid 0 immediately, in_ready 1.
